// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared types and constants for the single-precision FP
//               add/sub/compare execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10
    } fp_op_t;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_NORM   = 3'd1,
        CLS_DENORM = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } fp_class_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

    localparam logic [3:0] NZCV_EQ = 4'b0110;
    localparam logic [3:0] NZCV_LT = 4'b1000;
    localparam logic [3:0] NZCV_GT = 4'b0010;
    localparam logic [3:0] NZCV_UN = 4'b0011;

    // The reserved encoding 2'b11 executes as ADD.
    function automatic fp_op_t decode_op(input logic [1:0] op);
        case (op)
            2'b01:   decode_op = OP_SUB;
            2'b10:   decode_op = OP_CMP;
            default: decode_op = OP_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fadders.sv
// ============================================================================
// Module      : fadders
// Description : Combinational binary32 adder, round-to-nearest-even, with
//               denormal support. Inf/NaN operands are not handled here.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fadders (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    logic        w_swap;
    logic [31:0] w_big;
    logic [31:0] w_sml;
    logic [7:0]  w_eb;
    logic [7:0]  w_es;
    logic [7:0]  w_d;
    logic [26:0] w_mb;
    logic [26:0] w_ms_raw;
    logic [26:0] w_ms;
    logic        w_sticky;
    logic        w_sub;
    logic [26:0] w_ms_j;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [7:0]  w_shift;
    logic [26:0] w_norm;
    logic [8:0]  w_exp;
    logic        w_up;
    logic [30:0] w_mag;

    // Order by magnitude so the difference is never negative.
    assign w_swap   = i_a[30:0] < i_b[30:0];
    assign w_big    = w_swap ? i_b : i_a;
    assign w_sml    = w_swap ? i_a : i_b;
    assign w_eb     = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    assign w_es     = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    assign w_d      = w_eb - w_es;
    assign w_mb     = {|w_big[30:23], w_big[22:0], 3'b000};
    assign w_ms_raw = {|w_sml[30:23], w_sml[22:0], 3'b000};
    assign w_sub    = w_big[31] ^ w_sml[31];

    always_comb begin
        w_ms     = '0;
        w_sticky = |w_ms_raw;
        if (w_d < 8'd27) begin
            w_ms     = w_ms_raw >> w_d;
            w_sticky = |(w_ms_raw & ~({27{1'b1}} << w_d));
        end
    end

    assign w_ms_j = {w_ms[26:1], w_ms[0] | w_sticky};
    assign w_sum  = w_sub ? ({1'b0, w_mb} - {1'b0, w_ms_j})
                          : ({1'b0, w_mb} + {1'b0, w_ms_j});

    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (w_sum[i]) w_lz = 5'(26 - i);
    end

    // Left normalisation stops at the minimum exponent, yielding a denormal.
    always_comb begin
        w_shift = '0;
        w_norm  = '0;
        w_exp   = '0;
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], |w_sum[1:0]};
            w_exp  = {1'b0, w_eb} + 9'd1;
        end else begin
            w_shift = ({3'b000, w_lz} > (w_eb - 8'd1)) ? (w_eb - 8'd1) : {3'b000, w_lz};
            w_norm  = w_sum[26:0] << w_shift;
            w_exp   = {1'b0, w_eb} - {1'b0, w_shift};
            if (!w_norm[26]) w_exp = '0;
        end
    end

    assign w_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mag = {w_exp[7:0], w_norm[25:3]} + {30'd0, w_up};

    always_comb begin
        if (w_sum == 28'd0)
            o_sum = '0;
        else if (w_exp >= 9'd255)
            o_sum = {w_big[31], 8'hFF, 23'd0};
        else
            o_sum = {w_big[31], w_mag};
    end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_exec_classify.sv
// ============================================================================
// Module      : fp_classify
// Description : Combinational classification of a binary32 word into
//               zero / normal / denormal / infinity / NaN, plus its sign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] i_word,
    output fp_class_t   o_cls,
    output logic        o_sign
);

    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_exp  = i_word[30:23];
    assign w_frac = i_word[22:0];
    assign o_sign = i_word[31];

    always_comb begin
        o_cls = CLS_NORM;
        if (w_exp == 8'h00)
            o_cls = (w_frac == 23'd0) ? CLS_ZERO : CLS_DENORM;
        else if (w_exp == 8'hFF)
            o_cls = (w_frac == 23'd0) ? CLS_INF : CLS_NAN;
    end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_exec.sv
// ============================================================================
// Module      : fp_addsub_exec
// Description : Multi-cycle FADDS/FSUBS/FCMP execute stage with special-case
//               bypass around fadders. Optional sticky exception flags are
//               enabled by defining FP_EXC_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_addsub_exec
    import fp_pkg::*;
#(
    parameter int          FW   = 32,
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [FW-1:0] in_a,
    input  logic [FW-1:0] in_b,
    input  logic [4:0]    in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [FW-1:0] out_result,
    output logic [3:0]    out_flags,
    output logic          out_wr_en,
    output logic [4:0]    out_rd
`ifdef FP_EXC_FLAGS_EN
    ,
    input  logic          exc_clr,
    output logic          exc_invalid,
    output logic          exc_overflow
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]    r_state;
    fp_op_t        r_op;
    logic [FW-1:0] r_a;
    logic [FW-1:0] r_b;
    logic [4:0]    r_rd;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [FW-1:0] r_out_result;
    logic [3:0]    r_out_flags;
    logic          r_out_wr_en;
    logic [4:0]    r_out_rd;

    fp_class_t     w_a_cls;
    fp_class_t     w_b_cls;
    logic          w_a_sign;
    logic          w_b_sign;
    logic [FW-1:0] w_add;
    logic [FW-1:0] w_sel;
    logic [3:0]    w_flags;
    logic          w_is_cmp;
    logic          w_any_nan;
    logic          w_both_zero;

    fp_classify u_cls_a (.i_word(r_a), .o_cls(w_a_cls), .o_sign(w_a_sign));
    fp_classify u_cls_b (.i_word(r_b), .o_cls(w_b_cls), .o_sign(w_b_sign));
    fadders     u_add   (.i_a(r_a), .i_b(r_b), .o_sum(w_add));

    assign w_is_cmp    = (r_op == OP_CMP);
    assign w_any_nan   = (w_a_cls == CLS_NAN) || (w_b_cls == CLS_NAN);
    assign w_both_zero = (w_a_cls == CLS_ZERO) && (w_b_cls == CLS_ZERO);

    always_comb begin
        w_sel = w_add;
        if (w_any_nan)
            w_sel = QNAN;
        else if (w_a_cls == CLS_INF && w_b_cls == CLS_INF)
            w_sel = (w_a_sign != w_b_sign) ? QNAN : r_a;
        else if (w_a_cls == CLS_INF)
            w_sel = r_a;
        else if (w_b_cls == CLS_INF)
            w_sel = r_b;
        else if (w_both_zero)
            w_sel = (w_a_sign & w_b_sign) ? {1'b1, {(FW-1){1'b0}}} : '0;
        else if (w_a_cls == CLS_ZERO)
            w_sel = r_b;
        else if (w_b_cls == CLS_ZERO)
            w_sel = r_a;
    end

    // Sign-magnitude ordering; r_b is never inverted for CMP.
    always_comb begin
        w_flags = NZCV_GT;
        if (w_any_nan)
            w_flags = NZCV_UN;
        else if (w_both_zero || r_a == r_b)
            w_flags = NZCV_EQ;
        else if (w_a_sign != w_b_sign)
            w_flags = w_a_sign ? NZCV_LT : NZCV_GT;
        else if (w_a_sign)
            w_flags = (r_a[30:0] > r_b[30:0]) ? NZCV_LT : NZCV_GT;
        else
            w_flags = (r_a[30:0] < r_b[30:0]) ? NZCV_LT : NZCV_GT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_wr_en  <= 1'b0;
            r_out_rd     <= '0;
            r_op         <= OP_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_rd         <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op       <= decode_op(in_op);
                        r_a        <= in_a;
                        r_b        <= (decode_op(in_op) == OP_SUB) ? {~in_b[FW-1], in_b[FW-2:0]} : in_b;
                        r_rd       <= in_rd;
                        r_in_ready <= 1'b0;
                        r_state    <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_out_result <= w_is_cmp ? '0 : w_sel;
                    r_out_flags  <= w_is_cmp ? w_flags : 4'd0;
                    r_out_wr_en  <= ~w_is_cmp;
                    r_out_rd     <= r_rd;
                    r_out_valid  <= 1'b1;
                    r_state      <= c_RESP;
                end
                c_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef FP_EXC_FLAGS_EN
    logic w_set_invalid;
    logic w_set_overflow;
    logic r_exc_invalid;
    logic r_exc_overflow;
    logic r_err;

    assign w_set_invalid  = w_is_cmp ? w_any_nan
                          : (w_a_cls == CLS_INF && w_b_cls == CLS_INF && w_a_sign != w_b_sign);
    assign w_set_overflow = !w_is_cmp && !w_any_nan && (w_a_cls != CLS_INF)
                          && (w_b_cls != CLS_INF) && (w_add[30:23] == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst_n || exc_clr) begin
            r_exc_invalid  <= 1'b0;
            r_exc_overflow <= 1'b0;
        end else if (r_state == c_EXEC) begin
            r_exc_invalid  <= r_exc_invalid  | w_set_invalid;
            r_exc_overflow <= r_exc_overflow | w_set_overflow;
        end
    end

    // Protocol violation: a bundle offered while the stage is busy.
    always_ff @(posedge clk) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= r_err | (in_valid & ~r_in_ready);
    end

    assign exc_invalid  = r_exc_invalid;
    assign exc_overflow = r_exc_overflow;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;
    assign out_wr_en  = r_out_wr_en;
    assign out_rd     = r_out_rd;

endmodule

`default_nettype wire
